// File: rtl/cpu_checkpoint_irq_ctrl_if.sv
// Avalon-MM slave bus bundle for the checkpoint interrupt controller.
// The master modport is the bus side (the CPU fabric or a bench).
// The slave modport is the controller side.
interface cpu_checkpoint_irq_ctrl_if;
  logic [7:0]  avs_address;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;

  modport master (
    output avs_address,
    output avs_write,
    output avs_writedata,
    output avs_read,
    input  avs_readdata
  );

  modport slave (
    input  avs_address,
    input  avs_write,
    input  avs_writedata,
    input  avs_read,
    output avs_readdata
  );
endinterface

// File: rtl/cpu_checkpoint_irq_ctrl.sv
// Multi-core checkpoint interrupt controller.
// Each core has a checkpoint register. Writing it with bit 8 set raises a
// sticky, maskable pending bit. Any write to the register (re)arms that core's
// watchdog. A watchdog that counts down to zero without a fresh checkpoint
// latches an EXPIRED bit. Reads have a latency of one cycle.
module cpu_checkpoint_irq_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int TIMEOUT_W = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  cpu_checkpoint_irq_ctrl_if.slave  avs,
  output logic [NUM_CORES-1:0]      checkpoint_irq,
  output logic                      timeout_irq
);

  localparam logic [7:0] ADDR_PENDING = 8'h40;
  localparam logic [7:0] ADDR_MASK    = 8'h41;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h42;
  localparam logic [7:0] ADDR_EXPIRED = 8'h43;

  logic [31:0]          ckpt_q [NUM_CORES];
  logic [31:0]          ckpt_d [NUM_CORES];
  logic [TIMEOUT_W-1:0] wdog_q [NUM_CORES];
  logic [TIMEOUT_W-1:0] wdog_d [NUM_CORES];
  logic [NUM_CORES-1:0] pending_q, pending_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [NUM_CORES-1:0] expired_q, expired_d;
  logic [TIMEOUT_W-1:0] timeout_q, timeout_d;
  logic [31:0]          readdata_q, readdata_d;

  logic [NUM_CORES-1:0] ckpt_we;
  logic [NUM_CORES-1:0] ckpt_set;
  logic [NUM_CORES-1:0] wdog_fire;
  logic [NUM_CORES-1:0] pending_clr;
  logic [NUM_CORES-1:0] expired_clr;
  logic                 wr_mask;
  logic                 wr_timeout;
  logic [31:0]          ckpt_rd;
  logic [31:0]          rd_mux;

  // Decode the write strobe into per-register write enables and W1C masks.
  always_comb begin
    ckpt_we  = '0;
    ckpt_set = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      ckpt_we[n]  = avs.avs_write && (avs.avs_address == 8'(n));
      ckpt_set[n] = ckpt_we[n] && avs.avs_writedata[8];
    end
    wr_mask     = avs.avs_write && (avs.avs_address == ADDR_MASK);
    wr_timeout  = avs.avs_write && (avs.avs_address == ADDR_TIMEOUT);
    pending_clr = (avs.avs_write && (avs.avs_address == ADDR_PENDING)) ?
                  avs.avs_writedata[NUM_CORES-1:0] : '0;
    expired_clr = (avs.avs_write && (avs.avs_address == ADDR_EXPIRED)) ?
                  avs.avs_writedata[NUM_CORES-1:0] : '0;
  end

  // Per-core checkpoint storage and watchdog countdown; a checkpoint write
  // reloads the counter and so overrides an expiry due in the same cycle.
  always_comb begin
    ckpt_d    = ckpt_q;
    wdog_d    = wdog_q;
    wdog_fire = '0;
    for (int n = 0; n < NUM_CORES; n++) begin
      if (ckpt_we[n]) begin
        ckpt_d[n] = avs.avs_writedata;
        wdog_d[n] = timeout_q;
      end else if (wdog_q[n] == TIMEOUT_W'(1)) begin
        ckpt_d[n]    = ckpt_q[n];
        wdog_d[n]    = '0;
        wdog_fire[n] = 1'b1;
      end else if (wdog_q[n] != '0) begin
        ckpt_d[n] = ckpt_q[n];
        wdog_d[n] = wdog_q[n] - TIMEOUT_W'(1);
      end else begin
        ckpt_d[n] = ckpt_q[n];
        wdog_d[n] = wdog_q[n];
      end
    end
  end

  // Control registers; a set in the same cycle as a W1C of the same bit wins.
  always_comb begin
    pending_d = (pending_q & ~pending_clr) | ckpt_set;
    expired_d = (expired_q & ~expired_clr) | wdog_fire;
    if (wr_mask) begin
      mask_d = avs.avs_writedata[NUM_CORES-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (wr_timeout) begin
      timeout_d = avs.avs_writedata[TIMEOUT_W-1:0];
    end else begin
      timeout_d = timeout_q;
    end
  end

  // Read mux over the current register contents (the pre-write view when a
  // read and a write share a cycle); the result is captured only on a read.
  always_comb begin
    ckpt_rd = 32'h0;
    for (int n = 0; n < NUM_CORES; n++) begin
      ckpt_rd = ckpt_rd | ((avs.avs_address == 8'(n)) ? ckpt_q[n] : 32'h0);
    end
    case (avs.avs_address)
      ADDR_PENDING: rd_mux = 32'(pending_q);
      ADDR_MASK:    rd_mux = 32'(mask_q);
      ADDR_TIMEOUT: rd_mux = 32'(timeout_q);
      ADDR_EXPIRED: rd_mux = 32'(expired_q);
      default:      rd_mux = ckpt_rd;
    endcase
    if (avs.avs_read) begin
      readdata_d = rd_mux;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // State registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NUM_CORES; n++) begin
        ckpt_q[n] <= 32'h0;
        wdog_q[n] <= '0;
      end
      pending_q  <= '0;
      mask_q     <= '0;
      expired_q  <= '0;
      timeout_q  <= '0;
      readdata_q <= 32'h0;
    end else begin
      ckpt_q     <= ckpt_d;
      wdog_q     <= wdog_d;
      pending_q  <= pending_d;
      mask_q     <= mask_d;
      expired_q  <= expired_d;
      timeout_q  <= timeout_d;
      readdata_q <= readdata_d;
    end
  end

  assign avs.avs_readdata = readdata_q;
  assign checkpoint_irq   = pending_q & mask_q;
  assign timeout_irq      = |(expired_q & mask_q);

endmodule
